// File: rtl/jmp_unit_pkg.sv
// Shared types for the conditional-jump sequencer and the instruction decoder.
// cond_t encodes the 16 jump conditions; state_t is the sequencer FSM state.
package jmp_unit_pkg;

    typedef enum logic [3:0] {
        JMP    = 4'd0,
        JE     = 4'd1,
        JNE    = 4'd2,
        JL     = 4'd3,
        JLE    = 4'd4,
        JG     = 4'd5,
        JGE    = 4'd6,
        JB     = 4'd7,
        JBE    = 4'd8,
        JA     = 4'd9,
        JAE    = 4'd10,
        JO     = 4'd11,
        JNO    = 4'd12,
        JS     = 4'd13,
        JNS    = 4'd14,
        JNEVER = 4'd15
    } cond_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Condition code plus the flags captured when the jump was accepted.
    typedef struct packed {
        cond_t cond;
        logic  z;
        logic  o;
        logic  c;
        logic  s;
    } snap_t;

endpackage

// File: rtl/jmp_unit_cond_eval.sv
// Purely combinational jump-condition evaluator: cond_t plus Z/O/C/S -> taken.
// Signed "less" is s^o; unsigned "below" is c.
module cond_eval
    import jmp_unit_pkg::*;
(
    input  cond_t cond,
    input  logic  z,
    input  logic  o,
    input  logic  c,
    input  logic  s,
    output logic  taken
);

    logic lt;

    always_comb begin
        lt    = s ^ o;
        taken = 1'b0;
        case (cond)
            JMP:     taken = 1'b1;
            JE:      taken = z;
            JNE:     taken = !z;
            JL:      taken = lt;
            JLE:     taken = z | lt;
            JG:      taken = !z & !lt;
            JGE:     taken = !lt;
            JB:      taken = c;
            JBE:     taken = c | z;
            JA:      taken = !c & !z;
            JAE:     taken = !c;
            JO:      taken = o;
            JNO:     taken = !o;
            JS:      taken = s;
            JNS:     taken = !s;
            JNEVER:  taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/jmp_unit.sv
// Conditional-jump sequencer: snapshots cond/flags on start, fetches a 16-bit
// target high byte first, then pulses done (and pc_load when the jump is taken).
module jmp_unit
    import jmp_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cond,
    input  logic        zflag,
    input  logic        oflag,
    input  logic        cflag,
    input  logic        sflag,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic        mem_req,
    output logic        busy,
    output logic [15:0] pc_value,
    output logic        pc_load,
    output logic        taken,
    output logic        done
);

    state_t     state;
    state_t     next_state;
    snap_t      snap;
    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic       cond_true;

    // Memory handshake: mem_req is held high in both fetch states until a
    // cycle with mem_valid; mem_valid is ignored whenever mem_req is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            snap  <= '0;
            hi_q  <= 8'h00;
            lo_q  <= 8'h00;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                snap.cond <= cond_t'(cond);
                snap.z    <= zflag;
                snap.o    <= oflag;
                snap.c    <= cflag;
                snap.s    <= sflag;
            end
            if (state == FETCH_HI && mem_valid) hi_q <= mem_data;
            if (state == FETCH_LO && mem_valid) lo_q <= mem_data;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = FETCH_HI;
            end
            FETCH_HI: begin
                mem_req = 1'b1;
                if (mem_valid) next_state = FETCH_LO;
            end
            FETCH_LO: begin
                mem_req = 1'b1;
                if (mem_valid) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    cond_eval u_cond_eval (
        .cond  (snap.cond),
        .z     (snap.z),
        .o     (snap.o),
        .c     (snap.c),
        .s     (snap.s),
        .taken (cond_true)
    );

    assign taken    = done & cond_true;
    assign pc_load  = taken;
    assign pc_value = {hi_q, lo_q};

endmodule

// File: tb/tb_jmp_unit.sv
// Bench for jmp_unit: directed scenarios plus a full cond x flags sweep with
// random memory stalls, flag noise and start pulses while busy.
module tb_jmp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cond;
    logic        zflag, oflag, cflag, sflag;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        mem_req;
    logic        busy;
    logic [15:0] pc_value;
    logic        pc_load;
    logic        taken;
    logic        done;

    int errors = 0;
    int checks = 0;

    jmp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cond      (cond),
        .zflag     (zflag),
        .oflag     (oflag),
        .cflag     (cflag),
        .sflag     (sflag),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .mem_req   (mem_req),
        .busy      (busy),
        .pc_value  (pc_value),
        .pc_load   (pc_load),
        .taken     (taken),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: conditions phrased as relations of a prior compare a-b.
    function automatic logic ref_taken(input int c, input logic [3:0] fl);
        logic eq, less, below, ovf, neg;
        eq    = fl[3];
        ovf   = fl[2];
        below = fl[1];
        neg   = fl[0];
        less  = (neg != ovf);
        case (c)
            0:  return 1'b1;
            1:  return eq;
            2:  return !eq;
            3:  return less;
            4:  return less || eq;
            5:  return !(less || eq);
            6:  return !less;
            7:  return below;
            8:  return below || eq;
            9:  return !(below || eq);
            10: return !below;
            11: return ovf;
            12: return !ovf;
            13: return neg;
            14: return !neg;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full jump, starting in IDLE one time unit after a rising edge.
    // fl = {z,o,c,s}; wh/wl are wait cycles before each operand byte.
    task automatic run_jump(input int cc, input logic [3:0] fl, input logic [7:0] hi,
                            input logic [7:0] lo, input int wh, input int wl);
        logic exp_t;
        int   w;
        exp_t = ref_taken(cc, fl);
        check("idle_busy", 16'(busy), 16'd0);
        start     = 1'b1;
        cond      = 4'(cc);
        {zflag, oflag, cflag, sflag} = fl;
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = 8'($urandom);
        step();
        for (int ph = 0; ph < 2; ph++) begin
            w = (ph == 0) ? wh : wl;
            for (int i = 0; i <= w; i++) begin
                check("fetch_req", 16'(mem_req), 16'd1);
                check("fetch_busy", 16'(busy), 16'd1);
                check("fetch_no_done", 16'({done, pc_load, taken}), 16'd0);
                {zflag, oflag, cflag, sflag} = 4'($urandom);
                start     = 1'($urandom_range(0, 1));
                mem_valid = (i == w);
                mem_data  = (i == w) ? ((ph == 0) ? hi : lo) : 8'($urandom);
                step();
            end
        end
        check("done", 16'(done), 16'd1);
        check("done_busy", 16'(busy), 16'd1);
        check("done_req", 16'(mem_req), 16'd0);
        check("taken", 16'(taken), 16'(exp_t));
        check("pc_load", 16'(pc_load), 16'(exp_t));
        check("pc_value", pc_value, {hi, lo});
        start     = 1'($urandom_range(0, 1));
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = 8'($urandom);
        step();
        start     = 1'b0;
        mem_valid = 1'b0;
        check("post_done_quiet", 16'({done, pc_load, taken, busy, mem_req}), 16'd0);
        check("pc_hold", pc_value, {hi, lo});
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cond      = 4'd0;
        {zflag, oflag, cflag, sflag} = 4'b0000;
        mem_data  = 8'h00;
        mem_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_outputs", 16'({mem_req, busy, pc_load, taken, done}), 16'd0);
        check("reset_pc", pc_value, 16'h0000);
        mem_valid = 1'b1;
        mem_data  = 8'hEE;
        step();
        check("idle_ignores_mem", pc_value, 16'h0000);

        // Reset in the middle of FETCH_LO.
        start     = 1'b1;
        cond      = 4'd0;
        mem_valid = 1'b1;
        mem_data  = 8'h55;
        step();
        start     = 1'b0;
        step();
        mem_valid = 1'b0;
        check("lo_req", 16'(mem_req), 16'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_req", 16'(mem_req), 16'd0);
        check("async_rst_busy", 16'(busy), 16'd0);
        check("async_rst_pc", pc_value, 16'h0000);
        step();
        rst       = 1'b0;
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_done_after_rst", 16'({done, pc_load, busy}), 16'd0);
        end
        mem_valid = 1'b0;

        // Directed scenarios.
        run_jump(0, 4'b0000, 8'h12, 8'h34, 0, 0);
        run_jump(3, 4'b0001, 8'hAB, 8'hCD, 0, 0);
        run_jump(3, 4'b0101, 8'hAB, 8'hCD, 0, 0);
        run_jump(1, 4'b1000, 8'h20, 8'h40, 1, 0);
        run_jump(0, 4'b0000, 8'h9A, 8'hBC, 3, 2);
        run_jump(15, 4'b1111, 8'h77, 8'h88, 0, 1);

        // Exhaustive cond x flag sweep with random stalls and idle gaps.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                run_jump(c, 4'(f), 8'($urandom), 8'($urandom),
                         $urandom_range(0, 2), $urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
